decoder_scan: RTL

- Parametrised, registered binary-to-one-hot decoder; generalises the 3-to-8 decoder to SEL_W inputs and 2**SEL_W outputs.
- Direct mode: decodes a handshaked select word.
- Scan mode: auto-rotates the one-hot output at a programmable rate. Used as a digit/row select for multiplexed LED and 7-segment displays.
- Sits between the control logic and the display driver pins.

---
 rtl/decoder_pkg.sv | 24 ++
 rtl/scan_div.sv | 37 +++
 rtl/decoder_scan.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared definitions for the display select decoder.
//   state_e   : operating state of decoder_scan (IDLE / DIRECT / SCAN)
//   onehot()  : binary index -> one-hot vector. The result is MAX_OUT_W bits
//               wide; callers size-cast it down to their own OUT_W. This
//               bounds SEL_W to at most MAX_SEL_W.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 1 << MAX_SEL_W;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
    logic [MAX_OUT_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/scan_div.sv
// scan_div: programmable step divider for display scanning.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   en         : count this cycle (count is held when low)
//   clr        : synchronous clear to 0, wins over en
//   div_val    : terminal count; one tick every div_val+1 enabled cycles
//   tick       : combinational, high on the enabled cycle where count == div_val
// A div_val lowered below the running count is not caught early: the count
// runs on to its maximum, rolls to 0, and then meets the new terminal value.
module scan_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);

  logic [DIV_W-1:0] count_q, count_d;

  always_comb begin
    tick    = en & ~clr & (count_q == div_val);
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick ? '0 : count_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: registered binary-to-one-hot decoder with auto-scan, used as
// digit/row select for multiplexed LED and 7-segment displays.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : 0 blanks out (next cycle); divider and out_idx are held
//   mode       : 0 = direct decode of sel, 1 = auto scan
//   sel_valid, sel, sel_ready : select handshake (direct mode)
//   div_val    : scan step period minus 1, in clk cycles
//   scan_last  : last index of the scan sequence
//   out        : one-hot (or all-zero) registered output
//   out_idx    : binary index currently driven on out
//   wrap       : one-cycle pulse on the update that returns the scan to 0
// Handshake: a select word transfers on any cycle where sel_valid and
// sel_ready are both high; sel_ready is combinational (en & ~mode, forced low
// while in reset) and does not depend on sel_valid. The decoded word appears
// on out/out_idx one clock after the transfer.
// Build option DECODER_SCAN_BLANK_EN: each scan step first drives out=0 for one
// clock (anti-ghosting) before the new index lights; out_idx and wrap update
// on that blank cycle and the divider pauses during it.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int OUT_W = 2**SEL_W,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             sel_valid,
  input  logic [SEL_W-1:0] sel,
  output logic             sel_ready,
  input  logic [DIV_W-1:0] div_val,
  input  logic [SEL_W-1:0] scan_last,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] out_idx,
  output logic             wrap
);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic             div_en, div_clr, div_tick;
  logic [SEL_W-1:0] idx_step;
  logic             step_wrap;
`ifdef DECODER_SCAN_BLANK_EN
  logic             blank_q, blank_d;
`endif

  scan_div #(.DIV_W(DIV_W)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (div_en),
    .clr     (div_clr),
    .div_val (div_val),
    .tick    (div_tick)
  );

  // Next scan index. Using >= (not ==) means a scan_last lowered below the
  // current index wraps on the next tick instead of running off the end.
  always_comb begin
    step_wrap = (idx_q >= scan_last);
    idx_step  = step_wrap ? '0 : idx_q + SEL_W'(1);
  end

  always_comb begin
    state_d = !en ? IDLE : (mode ? SCAN : DIRECT);
    out_d   = out_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    div_en  = 1'b0;
    div_clr = 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
    blank_d = 1'b0;
`endif
    case (state_d)
      IDLE: begin
        out_d = '0;
      end
      DIRECT: begin
        if (sel_valid) begin
          idx_d = sel;
          out_d = OUT_W'(onehot(MAX_SEL_W'(sel)));
        end
      end
      SCAN: begin
        if (state_q != SCAN) begin
          // Fresh entry always restarts the sequence from index 0.
          idx_d   = '0;
          out_d   = OUT_W'(1);
          div_clr = 1'b1;
        end else begin
`ifdef DECODER_SCAN_BLANK_EN
          if (blank_q) begin
            out_d = OUT_W'(onehot(MAX_SEL_W'(idx_q)));
          end else begin
            div_en = 1'b1;
            if (div_tick) begin
              idx_d   = idx_step;
              wrap_d  = step_wrap;
              out_d   = '0;
              blank_d = 1'b1;
            end
          end
`else
          div_en = 1'b1;
          if (div_tick) begin
            idx_d  = idx_step;
            wrap_d = step_wrap;
            out_d  = OUT_W'(onehot(MAX_SEL_W'(idx_step)));
          end
`endif
        end
      end
      default: begin
        out_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
      blank_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
`ifdef DECODER_SCAN_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign sel_ready = en & ~mode & rst_n;
  assign out       = out_q;
  assign out_idx   = idx_q;
  assign wrap      = wrap_q;

endmodule
